// File: rtl/button_conditioner.sv
// Push-button conditioner: per-channel synchroniser, debouncer, press/release
// strobes and a typematic auto-repeat strobe, all in the pixel clock domain.
module button_conditioner #(
   parameter int NUM_BTN         = 5,
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 360000,
   parameter int REPEAT_DELAY    = 18000000,
   parameter int REPEAT_PERIOD   = 3600000
) (
   input  logic               pixel_clk,
   input  logic               sim_rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_repeat
);

   localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = $clog2(REP_MAX + 1);

   localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [REP_W-1:0] RD_LAST = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] RP_LAST = REP_W'(REPEAT_PERIOD - 1);

   generate
      if (NUM_BTN < 1) begin : g_bad_num_btn
         $error("button_conditioner: NUM_BTN must be >= 1");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("button_conditioner: SYNC_STAGES must be >= 2");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
         $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
      end
      if (REPEAT_DELAY < 1) begin : g_bad_delay
         $error("button_conditioner: REPEAT_DELAY must be >= 1");
      end
      if (REPEAT_PERIOD < 1) begin : g_bad_period
         $error("button_conditioner: REPEAT_PERIOD must be >= 1");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DELAY,
      ST_REPEAT
   } rep_state_e;

   // Synchroniser chain: stage 0 samples the raw pins, last stage feeds the debouncer.
   logic [SYNC_STAGES-1:0][NUM_BTN-1:0] sync_q, sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
   end

   always_ff @(posedge pixel_clk) begin
      if (sim_rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
      logic              sync_bit;
      logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
      logic              level_q, level_d;
      logic              press_q, press_d;
      logic              release_q, release_d;
      logic              repeat_q, repeat_d;
      logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
      rep_state_e        state_q, state_d;

      assign sync_bit = sync_q[SYNC_STAGES-1][i];

      // Debounce: count consecutive disagreeing cycles, flip level on the last one.
      always_comb begin
         db_cnt_d = '0;
         level_d  = level_q;
         if (sync_bit != level_q) begin
            if (db_cnt_q == DB_LAST) begin
               level_d = ~level_q;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end
         press_d   = level_d & ~level_q;
         release_d = ~level_d & level_q;
      end

      // Repeat FSM; a release overrides whatever state the channel is in.
      always_comb begin
         state_d   = state_q;
         rep_cnt_d = rep_cnt_q;
         repeat_d  = 1'b0;
         if (release_d) begin
            state_d   = ST_IDLE;
            rep_cnt_d = '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  if (press_d) begin
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                     state_d   = ST_DELAY;
                  end
               end
               ST_DELAY: begin
                  if (rep_cnt_q == RD_LAST) begin
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                     state_d   = ST_REPEAT;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
               ST_REPEAT: begin
                  if (rep_cnt_q == RP_LAST) begin
                     repeat_d  = 1'b1;
                     rep_cnt_d = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
               default: begin
                  state_d   = ST_IDLE;
                  rep_cnt_d = '0;
               end
            endcase
         end
      end

      always_ff @(posedge pixel_clk) begin
         if (sim_rst) begin
            db_cnt_q  <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            repeat_q  <= 1'b0;
            rep_cnt_q <= '0;
            state_q   <= ST_IDLE;
         end else begin
            db_cnt_q  <= db_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            repeat_q  <= repeat_d;
            rep_cnt_q <= rep_cnt_d;
            state_q   <= state_d;
         end
      end

      assign btn_level[i]   = level_q;
      assign btn_press[i]   = press_q;
      assign btn_release[i] = release_q;
      assign btn_repeat[i]  = repeat_q;
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short debounce/repeat timings.
module tb_button_conditioner;

   localparam int NB = 5;
   localparam int SS = 2;
   localparam int DC = 4;
   localparam int RD = 10;
   localparam int RP = 3;

   logic          pixel_clk = 1'b0;
   logic          sim_rst   = 1'b1;
   logic [NB-1:0] btn_raw   = '0;
   logic [NB-1:0] btn_level, btn_press, btn_release, btn_repeat;

   button_conditioner #(
      .NUM_BTN(NB), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DC),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) dut (
      .pixel_clk  (pixel_clk),
      .sim_rst    (sim_rst),
      .btn_raw    (btn_raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_repeat (btn_repeat)
   );

   always #5 pixel_clk = ~pixel_clk;

   typedef struct packed {
      logic [NB-1:0] lvl;
      logic [NB-1:0] prs;
      logic [NB-1:0] rel;
      logic [NB-1:0] rep;
   } exp_t;

   exp_t exp_q[$];

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [NB-1:0] m_sync0 = '0;
   logic [NB-1:0] m_sync1 = '0;
   logic [NB-1:0] m_lvl   = '0;
   int            m_cnt[NB];
   int            m_pt[NB];
   int            t = 0;

   int n_press[NB];
   int n_rel[NB];
   int n_rep[NB];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at t=%0d: got=%0h expected=%0h", tag, t, got, exp);
      end
   endtask

   task automatic clear_counts();
      for (int c = 0; c < NB; c++) begin
         n_press[c] = 0;
         n_rel[c]   = 0;
         n_rep[c]   = 0;
      end
   endtask

   // Model of one rising edge; the expected post-edge outputs go to the queue.
   task automatic model_edge(input logic [NB-1:0] raw, input logic rst);
      exp_t          e;
      logic [NB-1:0] prev;
      int            dt;
      t++;
      e = '0;
      if (rst) begin
         m_sync0 = '0;
         m_sync1 = '0;
         m_lvl   = '0;
         for (int c = 0; c < NB; c++) m_cnt[c] = 0;
      end else begin
         prev = m_lvl;
         for (int c = 0; c < NB; c++) begin
            if (m_sync1[c] != m_lvl[c]) begin
               m_cnt[c]++;
               if (m_cnt[c] == DC) begin
                  m_lvl[c] = m_sync1[c];
                  m_cnt[c] = 0;
               end
            end else begin
               m_cnt[c] = 0;
            end
         end
         e.lvl = m_lvl;
         e.prs = m_lvl & ~prev;
         e.rel = ~m_lvl & prev;
         for (int c = 0; c < NB; c++) begin
            if (e.prs[c]) m_pt[c] = t;
            dt = t - m_pt[c];
            e.rep[c] = m_lvl[c] && ((dt == 0) || (dt >= RD && ((dt - RD) % RP) == 0));
         end
         m_sync1 = m_sync0;
         m_sync0 = raw;
      end
      exp_q.push_back(e);
   endtask

   task automatic step(input logic [NB-1:0] raw, input logic rst);
      exp_t e;
      @(negedge pixel_clk);
      btn_raw = raw;
      sim_rst = rst;
      model_edge(raw, rst);
      @(posedge pixel_clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("level",   32'(btn_level),   32'(e.lvl));
         check("press",   32'(btn_press),   32'(e.prs));
         check("release", 32'(btn_release), 32'(e.rel));
         check("repeat",  32'(btn_repeat),  32'(e.rep));
      end
      for (int c = 0; c < NB; c++) begin
         n_press[c] += int'(btn_press[c]);
         n_rel[c]   += int'(btn_release[c]);
         n_rep[c]   += int'(btn_repeat[c]);
      end
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, 1'b0);
   endtask

   initial begin
      logic [NB-1:0] raw;
      logic [8:0]    bounce;
      for (int c = 0; c < NB; c++) begin
         m_cnt[c] = 0;
         m_pt[c]  = -1000;
      end
      clear_counts();

      // Reset with all buttons held, then re-debounce after reset.
      for (int k = 0; k < 3; k++) step(5'b11111, 1'b1);
      check("rst_level", 32'(btn_level), 32'd0);
      check("rst_press", 32'(btn_press), 32'd0);
      for (int k = 1; k <= 20; k++) begin
         step(5'b11111, 1'b0);
         if (k == 5) check("all_level_e5", 32'(btn_level), 32'd0);
         if (k == 6) check("all_level_e6", 32'(btn_level), 32'h1f);
      end
      idle(12);
      for (int c = 0; c < NB; c++) begin
         check("all_press_cnt", 32'(n_press[c]), 32'd1);
         check("all_rel_cnt",   32'(n_rel[c]),   32'd1);
      end

      // Short glitch on bit 1 is rejected.
      clear_counts();
      for (int k = 0; k < 3; k++) step(5'b00010, 1'b0);
      idle(10);
      check("glitch_press", 32'(n_press[1]), 32'd0);
      check("glitch_rep",   32'(n_rep[1]),   32'd0);

      // Bit 0: press, repeats at P, P+10, P+13, P+16, release raw after P+11.
      clear_counts();
      for (int k = 1; k <= 17; k++) begin
         step(5'b00001, 1'b0);
         if (k == 6) check("b0_press_at_P", 32'(btn_press[0]), 32'd1);
      end
      for (int k = 1; k <= 12; k++) begin
         step('0, 1'b0);
         if (k == 6) check("b0_release_P17", 32'(btn_release[0]), 32'd1);
      end
      check("b0_rep_cnt",   32'(n_rep[0]),   32'd4);
      check("b0_press_cnt", 32'(n_press[0]), 32'd1);

      // Bounce on bit 2.
      clear_counts();
      bounce = 9'b111101101;
      for (int k = 0; k < 9; k++) begin
         step(bounce[k] ? 5'b00100 : 5'b00000, 1'b0);
         if (k == 8) check("bounce_lvl_early", 32'(btn_level[2]), 32'd0);
      end
      for (int k = 1; k <= 6; k++) begin
         step(5'b00100, 1'b0);
         if (k == 1) check("bounce_lvl_rise", 32'(btn_level[2]), 32'd0);
         if (k == 2) check("bounce_lvl_on",   32'(btn_level[2]), 32'd1);
      end
      idle(10);
      check("bounce_press_cnt", 32'(n_press[2]), 32'd1);

      // Reset during DELAY on bit 3 while held.
      clear_counts();
      for (int k = 0; k < 10; k++) step(5'b01000, 1'b0);
      step(5'b01000, 1'b1);
      check("midrst_level", 32'(btn_level), 32'd0);
      step(5'b01000, 1'b1);
      clear_counts();
      for (int k = 1; k <= 20; k++) begin
         step(5'b01000, 1'b0);
         if (k == 6) check("midrst_press", 32'(btn_press[3]), 32'd1);
      end
      check("midrst_rep_cnt", 32'(n_rep[3]), 32'd3);
      idle(10);

      // Random slowly-changing buttons with occasional resets.
      raw = '0;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 5) == 0) raw[$urandom_range(0, NB - 1)] ^= 1'b1;
         step(raw, $urandom_range(0, 120) == 0);
      end
      idle(12);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
